// File: rtl/mul_pipe_ctrl_if.sv
// Decode, write-port and pipeline-status signals between the multiply
// sequencing controller and the surrounding core.
`timescale 1ns/1ps
interface mul_pipe_ctrl_if #(
   parameter int unsigned STAGES        = 5,
   parameter int unsigned REG_ADDR_SIZE = 5
);
   logic                     MC_dec_valid;
   logic                     MC_dec_is_mul;
   logic [REG_ADDR_SIZE-1:0] MC_dec_rs1;
   logic [REG_ADDR_SIZE-1:0] MC_dec_rs2;
   logic [REG_ADDR_SIZE-1:0] MC_dec_rd;
   logic                     MC_flush;
   logic                     MC_alu_wb_valid;
   logic                     MC_issue;
   logic                     MC_hazard;
   logic [STAGES-1:0]        MC_stage_in_use;
   logic [STAGES-1:0]        MC_stage_stall;
   logic                     MC_wb_en;
   logic                     MC_wb_sel;
   logic [REG_ADDR_SIZE-1:0] MC_wb_rd;
   logic                     MC_alu_wb_stall;
   logic                     MC_busy;

   modport master (
      output MC_dec_valid, MC_dec_is_mul, MC_dec_rs1, MC_dec_rs2, MC_dec_rd,
             MC_flush, MC_alu_wb_valid,
      input  MC_issue, MC_hazard, MC_stage_in_use, MC_stage_stall, MC_wb_en,
             MC_wb_sel, MC_wb_rd, MC_alu_wb_stall, MC_busy
   );

   modport slave (
      input  MC_dec_valid, MC_dec_is_mul, MC_dec_rs1, MC_dec_rs2, MC_dec_rd,
             MC_flush, MC_alu_wb_valid,
      output MC_issue, MC_hazard, MC_stage_in_use, MC_stage_stall, MC_wb_en,
             MC_wb_sel, MC_wb_rd, MC_alu_wb_stall, MC_busy
   );
endinterface

// File: rtl/mul_pipe_ctrl.sv
// Multiply pipeline sequencer: per-stage valid/rd tracking, bubble-collapsing
// stall chain, decode hazard detection and write-port arbitration vs. the ALU.
`timescale 1ns/1ps
module mul_pipe_ctrl #(
   parameter int unsigned STAGES        = 5,
   parameter int unsigned REG_ADDR_SIZE = 5
) (
   input  logic           clk,
   input  logic           reset,
   mul_pipe_ctrl_if.slave mc
);
   localparam int unsigned LAST = STAGES - 1;

   logic [STAGES-1:0]        valid_q;
   logic [REG_ADDR_SIZE-1:0] rd_q [STAGES];
   logic                     prio_alu_q;

   logic [STAGES-1:0] stall;
   logic              match;
   logic              hazard;
   logic              issue;
   logic              mul_req;
   logic              alu_req;
   logic              mul_grant;
   logic              alu_grant;
   logic              conflict;

   // Multiply is suppressed entirely during a flush; the ALU takes the port.
   always_comb begin
      mul_req   = valid_q[LAST] & ~mc.MC_flush;
      alu_req   = mc.MC_alu_wb_valid;
      conflict  = mul_req & alu_req;
      mul_grant = mul_req & (~alu_req | ~prio_alu_q);
      alu_grant = alu_req & ~mul_grant;
   end

   // Stall only propagates through occupied stages, so bubbles collapse.
   always_comb begin
      stall       = '0;
      stall[LAST] = valid_q[LAST] & ~mul_grant;
      for (int i = int'(STAGES) - 2; i >= 0; i--) begin
         stall[i] = valid_q[i] & stall[i+1];
      end
   end

   // RAW and WAW check against every in-flight destination; r0 never matches.
   always_comb begin
      match = 1'b0;
      for (int i = 0; i < int'(STAGES); i++) begin
         if (valid_q[i]) begin
            if ((mc.MC_dec_rs1 != '0 && mc.MC_dec_rs1 == rd_q[i]) ||
                (mc.MC_dec_rs2 != '0 && mc.MC_dec_rs2 == rd_q[i]) ||
                (mc.MC_dec_rd  != '0 && mc.MC_dec_rd  == rd_q[i])) begin
               match = 1'b1;
            end
         end
      end
      hazard = mc.MC_dec_valid & match;
      issue  = mc.MC_dec_valid & mc.MC_dec_is_mul & ~hazard & ~stall[0] & ~mc.MC_flush;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q    <= '0;
         prio_alu_q <= 1'b0;
         for (int i = 0; i < int'(STAGES); i++) begin
            rd_q[i] <= '0;
         end
      end else begin
         if (!stall[0]) begin
            valid_q[0] <= issue;
            rd_q[0]    <= mc.MC_dec_rd;
         end
         for (int i = 1; i < int'(STAGES); i++) begin
            if (!stall[i]) begin
               valid_q[i] <= valid_q[i-1];
               rd_q[i]    <= rd_q[i-1];
            end
         end
         if (mc.MC_flush) begin
            valid_q <= '0;
         end
         // Whoever wins a conflict yields priority next time.
         if (conflict) begin
            prio_alu_q <= mul_grant;
         end
      end
   end

   assign mc.MC_issue        = issue;
   assign mc.MC_hazard       = hazard;
   assign mc.MC_stage_in_use = valid_q;
   assign mc.MC_stage_stall  = stall;
   assign mc.MC_wb_en        = mul_grant | alu_grant;
   assign mc.MC_wb_sel       = mul_grant;
   assign mc.MC_wb_rd        = rd_q[LAST];
   assign mc.MC_alu_wb_stall = alu_req & ~alu_grant;
   assign mc.MC_busy         = |valid_q;
endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Directed bench for mul_pipe_ctrl: issue latency, arbitration fairness,
// bubble collapse, hazards, flush and asynchronous reset.
`timescale 1ns/1ps
module tb_mul_pipe_ctrl;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;

   mul_pipe_ctrl_if #(.STAGES(5), .REG_ADDR_SIZE(5)) bus ();

   mul_pipe_ctrl #(.STAGES(5), .REG_ADDR_SIZE(5)) dut (
      .clk   (clk),
      .reset (reset),
      .mc    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic drive(input logic v, input logic m, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic fl, input logic alu);
      bus.MC_dec_valid    = v;
      bus.MC_dec_is_mul   = m;
      bus.MC_dec_rs1      = rs1;
      bus.MC_dec_rs2      = rs2;
      bus.MC_dec_rd       = rd;
      bus.MC_flush        = fl;
      bus.MC_alu_wb_valid = alu;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) next_cycle();
      n_cmp++; if (bus.MC_stage_in_use !== 5'b0) begin n_fail++; $display("FAIL reset.in_use got=%b exp=00000", bus.MC_stage_in_use); end
      n_cmp++; if (bus.MC_busy !== 1'b0) begin n_fail++; $display("FAIL reset.busy got=%b exp=0", bus.MC_busy); end
      n_cmp++; if ({bus.MC_issue, bus.MC_hazard, bus.MC_wb_en, bus.MC_wb_sel, bus.MC_alu_wb_stall} !== 5'b0)
         begin n_fail++; $display("FAIL reset.flags got=%b exp=00000", {bus.MC_issue, bus.MC_hazard, bus.MC_wb_en, bus.MC_wb_sel, bus.MC_alu_wb_stall}); end
      n_cmp++; if ({bus.MC_stage_stall, bus.MC_wb_rd} !== 10'b0) begin n_fail++; $display("FAIL reset.stall_rd got=%b exp=0", {bus.MC_stage_stall, bus.MC_wb_rd}); end
      drive(1, 0, 3, 3, 3, 0, 0);
      #1;
      n_cmp++; if (bus.MC_hazard !== 1'b0) begin n_fail++; $display("FAIL reset.hazard_empty got=%b exp=0", bus.MC_hazard); end
      drive(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      next_cycle();
   endtask

   task automatic test_single();
      logic [4:0] exp_use;
      for (int c = 0; c <= 6; c++) begin
         if (c == 0) drive(1, 1, 0, 0, 3, 0, 0);
         else        drive(0, 0, 0, 0, 0, 0, 0);
         exp_use = (c >= 1 && c <= 5) ? 5'(1 << (c - 1)) : 5'b0;
         @(negedge clk);
         n_cmp++; if (bus.MC_issue !== (c == 0)) begin n_fail++; $display("FAIL single.issue c=%0d got=%b", c, bus.MC_issue); end
         n_cmp++; if (bus.MC_stage_in_use !== exp_use) begin n_fail++; $display("FAIL single.in_use c=%0d got=%b exp=%b", c, bus.MC_stage_in_use, exp_use); end
         n_cmp++; if ({bus.MC_wb_en, bus.MC_wb_sel} !== ((c == 5) ? 2'b11 : 2'b00))
            begin n_fail++; $display("FAIL single.wb c=%0d got=%b%b", c, bus.MC_wb_en, bus.MC_wb_sel); end
         if (c == 5) begin
            n_cmp++; if (bus.MC_wb_rd !== 5'd3) begin n_fail++; $display("FAIL single.wb_rd got=%0d exp=3", bus.MC_wb_rd); end
         end
         n_cmp++; if (bus.MC_busy !== (c >= 1 && c <= 5)) begin n_fail++; $display("FAIL single.busy c=%0d got=%b", c, bus.MC_busy); end
         next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      logic exp_sel;
      for (int c = 0; c <= 15; c++) begin
         if (c < 5) drive(1, 1, 0, 0, 5'(c + 1), 0, 0);
         else       drive(0, 0, 0, 0, 0, 0, (c <= 14));
         exp_sel = (c >= 5 && c <= 13 && (c % 2) == 1);
         @(negedge clk);
         if (c < 5) begin
            n_cmp++; if (bus.MC_issue !== 1'b1) begin n_fail++; $display("FAIL b2b.issue c=%0d got=%b exp=1", c, bus.MC_issue); end
         end
         n_cmp++; if (bus.MC_wb_en !== (c >= 5 && c <= 14)) begin n_fail++; $display("FAIL b2b.wb_en c=%0d got=%b", c, bus.MC_wb_en); end
         n_cmp++; if (bus.MC_wb_sel !== exp_sel) begin n_fail++; $display("FAIL b2b.wb_sel c=%0d got=%b exp=%b", c, bus.MC_wb_sel, exp_sel); end
         n_cmp++; if (bus.MC_alu_wb_stall !== exp_sel) begin n_fail++; $display("FAIL b2b.alu_stall c=%0d got=%b exp=%b", c, bus.MC_alu_wb_stall, exp_sel); end
         if (exp_sel) begin
            n_cmp++; if (bus.MC_wb_rd !== 5'((c - 3) / 2)) begin n_fail++; $display("FAIL b2b.wb_rd c=%0d got=%0d exp=%0d", c, bus.MC_wb_rd, (c - 3) / 2); end
         end
         if (c == 6) begin
            n_cmp++; if (bus.MC_stage_stall !== 5'b11110) begin n_fail++; $display("FAIL b2b.stall c=6 got=%b exp=11110", bus.MC_stage_stall); end
         end
         if (c == 15) begin
            n_cmp++; if (bus.MC_busy !== 1'b0) begin n_fail++; $display("FAIL b2b.busy_end got=%b exp=0", bus.MC_busy); end
         end
         next_cycle();
      end
   endtask

   // Runs right after test_back_to_back, whose last conflict leaves prio_alu=1.
   task automatic test_bubble_collapse();
      for (int c = 0; c <= 9; c++) begin
         if (c == 0)      drive(1, 1, 0, 0, 8, 0, 0);
         else if (c == 2) drive(1, 1, 0, 0, 9, 0, 0);
         else             drive(0, 0, 0, 0, 0, 0, (c >= 5 && c <= 8));
         @(negedge clk);
         if (c == 5) begin
            n_cmp++; if (bus.MC_stage_in_use !== 5'b10100) begin n_fail++; $display("FAIL bubble.in_use5 got=%b exp=10100", bus.MC_stage_in_use); end
            n_cmp++; if (bus.MC_stage_stall !== 5'b10000) begin n_fail++; $display("FAIL bubble.stall5 got=%b exp=10000", bus.MC_stage_stall); end
            n_cmp++; if ({bus.MC_wb_en, bus.MC_wb_sel, bus.MC_alu_wb_stall} !== 3'b100) begin n_fail++; $display("FAIL bubble.alu_win5 got=%b exp=100", {bus.MC_wb_en, bus.MC_wb_sel, bus.MC_alu_wb_stall}); end
         end
         if (c == 6) begin
            n_cmp++; if (bus.MC_stage_in_use !== 5'b11000) begin n_fail++; $display("FAIL bubble.in_use6 got=%b exp=11000", bus.MC_stage_in_use); end
            n_cmp++; if ({bus.MC_wb_sel, bus.MC_alu_wb_stall, bus.MC_wb_rd} !== {2'b11, 5'd8}) begin n_fail++; $display("FAIL bubble.wb6 got=%b%b rd=%0d exp=11 rd=8", bus.MC_wb_sel, bus.MC_alu_wb_stall, bus.MC_wb_rd); end
         end
         if (c == 7) begin
            n_cmp++; if ({bus.MC_stage_stall, bus.MC_wb_sel} !== {5'b10000, 1'b0}) begin n_fail++; $display("FAIL bubble.alu_win7 stall=%b sel=%b exp=10000 0", bus.MC_stage_stall, bus.MC_wb_sel); end
         end
         if (c == 8) begin
            n_cmp++; if ({bus.MC_wb_sel, bus.MC_alu_wb_stall, bus.MC_wb_rd} !== {2'b11, 5'd9}) begin n_fail++; $display("FAIL bubble.wb8 got=%b%b rd=%0d exp=11 rd=9", bus.MC_wb_sel, bus.MC_alu_wb_stall, bus.MC_wb_rd); end
         end
         if (c == 9) begin
            n_cmp++; if (bus.MC_busy !== 1'b0) begin n_fail++; $display("FAIL bubble.busy9 got=%b exp=0", bus.MC_busy); end
         end
         next_cycle();
      end
   endtask

   task automatic test_hazard();
      apply_reset();
      for (int c = 0; c <= 14; c++) begin
         if (c == 0)                drive(1, 1, 0, 0, 7, 0, 0);
         else if (c <= 3)           drive(1, 0, 2, 7, 4, 0, 0);
         else if (c <= 7)           drive(1, 0, 0, 0, 7, 0, 0);
         else if (c == 8)           drive(1, 1, 0, 0, 0, 0, 0);
         else if (c <= 12)          drive(1, 0, 0, 0, 0, 0, 0);
         else                       drive(0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         n_cmp++; if (bus.MC_hazard !== (c >= 1 && c <= 5)) begin n_fail++; $display("FAIL hazard.flag c=%0d got=%b", c, bus.MC_hazard); end
         n_cmp++; if (bus.MC_issue !== (c == 0 || c == 8)) begin n_fail++; $display("FAIL hazard.issue c=%0d got=%b", c, bus.MC_issue); end
         if (c == 5 || c == 13) begin
            n_cmp++; if ({bus.MC_wb_en, bus.MC_wb_sel, bus.MC_wb_rd} !== {2'b11, (c == 5) ? 5'd7 : 5'd0})
               begin n_fail++; $display("FAIL hazard.wb c=%0d got=%b%b rd=%0d", c, bus.MC_wb_en, bus.MC_wb_sel, bus.MC_wb_rd); end
         end
         next_cycle();
      end
   endtask

   task automatic test_flush();
      apply_reset();
      for (int c = 0; c <= 9; c++) begin
         if (c <= 2)      drive(1, 1, 0, 0, 5'(c + 1), 0, 0);
         else if (c == 3) drive(1, 1, 0, 0, 4, 1, 1);
         else             drive(0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         if (c == 3) begin
            n_cmp++; if (bus.MC_stage_in_use !== 5'b00111) begin n_fail++; $display("FAIL flush.in_use3 got=%b exp=00111", bus.MC_stage_in_use); end
            n_cmp++; if (bus.MC_issue !== 1'b0) begin n_fail++; $display("FAIL flush.issue3 got=%b exp=0", bus.MC_issue); end
            n_cmp++; if ({bus.MC_wb_en, bus.MC_wb_sel, bus.MC_alu_wb_stall} !== 3'b100) begin n_fail++; $display("FAIL flush.alu3 got=%b exp=100", {bus.MC_wb_en, bus.MC_wb_sel, bus.MC_alu_wb_stall}); end
         end
         if (c >= 4) begin
            n_cmp++; if ({bus.MC_stage_in_use, bus.MC_busy, bus.MC_wb_en} !== 7'b0) begin n_fail++; $display("FAIL flush.after c=%0d use=%b busy=%b wb=%b exp=0", c, bus.MC_stage_in_use, bus.MC_busy, bus.MC_wb_en); end
         end
         next_cycle();
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      drive(1, 1, 0, 0, 1, 0, 0);
      next_cycle();
      drive(1, 1, 0, 0, 2, 0, 0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++; if (bus.MC_stage_in_use !== 5'b00011) begin n_fail++; $display("FAIL areset.before got=%b exp=00011", bus.MC_stage_in_use); end
      #1;
      reset = 1'b1;
      #1;
      n_cmp++; if ({bus.MC_stage_in_use, bus.MC_busy, bus.MC_stage_stall} !== 11'b0) begin n_fail++; $display("FAIL areset.state use=%b busy=%b stall=%b exp=0", bus.MC_stage_in_use, bus.MC_busy, bus.MC_stage_stall); end
      n_cmp++; if ({bus.MC_issue, bus.MC_hazard, bus.MC_wb_en, bus.MC_wb_sel, bus.MC_alu_wb_stall, bus.MC_wb_rd} !== 10'b0) begin n_fail++; $display("FAIL areset.outs got=%b exp=0", {bus.MC_issue, bus.MC_hazard, bus.MC_wb_en, bus.MC_wb_sel, bus.MC_alu_wb_stall, bus.MC_wb_rd}); end
      next_cycle();
      reset = 1'b0;
      for (int c = 0; c <= 6; c++) begin
         if (c == 0) drive(1, 1, 0, 0, 6, 0, 0);
         else        drive(0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         n_cmp++; if (bus.MC_wb_en !== (c == 5)) begin n_fail++; $display("FAIL areset.wb_en c=%0d got=%b", c, bus.MC_wb_en); end
         if (c == 5) begin
            n_cmp++; if ({bus.MC_wb_sel, bus.MC_wb_rd} !== {1'b1, 5'd6}) begin n_fail++; $display("FAIL areset.wb got sel=%b rd=%0d exp sel=1 rd=6", bus.MC_wb_sel, bus.MC_wb_rd); end
         end
         next_cycle();
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_bubble_collapse();
      test_hazard();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
